// File: rtl/demux_1_8_deser.sv
// -----------------------------------------------------------------------------
// demux_1_8_deser
//
// Sequential 1-to-WIDTH demultiplexer / deserializer. One serial bit is
// accepted per cycle (in_valid & in_ready) and steered into a lane of the
// output word. The lane comes either from an internal auto-incrementing
// pointer (mode=0) or from the select input (mode=1). A per-lane written-mask
// tracks completion; once every lane has been written, the word is presented
// on data_out with out_valid until the consumer takes it (out_ready).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   data_in    in   serial data bit
//   in_valid   in   data_in is valid this cycle
//   in_ready   out  block accepts data_in this cycle
//   mode       in   0 = auto lane pointer, 1 = explicit lane from select
//   select     in   [SEL_W] target lane in explicit mode
//   data_out   out  [WIDTH] assembled word, lane k = bit k
//   out_valid  out  data_out holds a complete word
//   out_ready  in   consumer takes the word
//   lane_ptr   out  [SEL_W] next auto lane
//   overrun    out  sticky: a bit was offered while in_ready was low
// -----------------------------------------------------------------------------
module demux_1_8_deser #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3    // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] lane_ptr,
    output logic             overrun
);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t           r_state,     w_state_next;
    logic [WIDTH-1:0] r_data,      w_data_next;
    logic [WIDTH-1:0] r_mask,      w_mask_next;
    logic [SEL_W-1:0] r_ptr,       w_ptr_next;
    logic             r_out_valid, w_out_valid_next;
    logic             r_overrun,   w_overrun_next;
    logic             r_mode;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_mode_chg;
    logic [WIDTH-1:0] w_base_mask;
    logic [SEL_W-1:0] w_base_ptr;
    logic [SEL_W-1:0] w_ptr_inc;
    logic [SEL_W-1:0] w_lane;
    logic [WIDTH-1:0] w_lane_hit;
    logic [WIDTH-1:0] w_mask_upd;
    logic [WIDTH-1:0] w_data_upd;
    logic             w_full;

    // In HOLD the block can take a new bit only when the held word is being
    // consumed in the same cycle; that bit then starts the next word.
    assign w_in_ready = (r_state == S_COLLECT) ? 1'b1 : out_ready;
    assign w_accept   = in_valid & w_in_ready;

    // A mode change while collecting throws away the partial word. Folding
    // that into "base" mask/pointer lets the same-cycle bit be treated as the
    // first bit of a fresh word under the new mode. In HOLD the mask and
    // pointer are already zero, so no special case is needed there.
    assign w_mode_chg  = (r_state == S_COLLECT) && (mode != r_mode);
    assign w_base_mask = w_mode_chg ? '0 : r_mask;
    assign w_base_ptr  = w_mode_chg ? '0 : r_ptr;
    assign w_ptr_inc   = (w_base_ptr == SEL_W'(WIDTH - 1)) ? '0 : (w_base_ptr + SEL_W'(1));
    assign w_lane      = mode ? select : w_base_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign w_lane_hit[gi] = w_accept && (w_lane == SEL_W'(gi));
            assign w_mask_upd[gi] = w_base_mask[gi] | w_lane_hit[gi];
            assign w_data_upd[gi] = w_lane_hit[gi] ? data_in : r_data[gi];
        end
    endgenerate

    assign w_full = &w_mask_upd;

    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = r_out_valid;
        w_mask_next      = w_base_mask;
        w_ptr_next       = w_base_ptr;
        w_data_next      = w_data_upd;
        w_overrun_next   = r_overrun | (in_valid & ~w_in_ready);

        if (w_accept) begin
            w_mask_next = w_mask_upd;
            w_ptr_next  = mode ? w_base_ptr : w_ptr_inc;
            if (w_full) begin
                w_state_next     = S_HOLD;
                w_out_valid_next = 1'b1;
                w_mask_next      = '0;
                w_ptr_next       = '0;
            end else if (r_state == S_HOLD) begin
                // Accept in HOLD implies out_ready: held word is consumed.
                w_state_next     = S_COLLECT;
                w_out_valid_next = 1'b0;
            end
        end else if ((r_state == S_HOLD) && out_ready) begin
            w_state_next     = S_COLLECT;
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_data      <= '0;
            r_mask      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_mode      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_data      <= w_data_next;
            r_mask      <= w_mask_next;
            r_ptr       <= w_ptr_next;
            r_out_valid <= w_out_valid_next;
            r_overrun   <= w_overrun_next;
            r_mode      <= mode;
        end
    end

    assign in_ready  = w_in_ready;
    assign data_out  = r_data;
    assign out_valid = r_out_valid;
    assign lane_ptr  = r_ptr;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// -----------------------------------------------------------------------------
// tb_demux_1_8_deser
//
// Directed bench for demux_1_8_deser: auto fill, explicit fill, duplicate
// explicit lane, backpressure/overrun, simultaneous consume+accept, and reset
// in the middle of a word. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_demux_1_8_deser;

    logic       clk;
    logic       rst_n;
    logic       data_in;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [2:0] select;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] lane_ptr;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    demux_1_8_deser #(.WIDTH(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_ptr  (lane_ptr),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted bit on the next edge, then in_valid drops.
    task automatic push(input logic b, input logic [2:0] sel);
        in_valid = 1'b1;
        data_in  = b;
        select   = sel;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] lanes_dup;

        rst_n     = 1'b0;
        data_in   = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        select    = 3'd0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_data_out",  32'(data_out),  32'h00);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_lane_ptr",  32'(lane_ptr),  32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        rst_n = 1'b1;
        tick();

        // Auto mode fill: 0,1,0,1,... lane 0 first -> 8'hAA
        pat = 8'hAA;
        for (int i = 0; i < 7; i++) push(pat[i], 3'd0);
        check("auto_valid_before_last", 32'(out_valid), 32'h0);
        check("auto_ptr_before_last",   32'(lane_ptr),  32'h7);
        push(pat[7], 3'd0);
        check("auto_valid", 32'(out_valid), 32'h1);
        check("auto_data",  32'(data_out),  32'hAA);
        check("auto_ptr",   32'(lane_ptr),  32'h0);

        // Backpressure: held word, offer a bit with out_ready=0
        in_valid = 1'b1;
        data_in  = 1'b1;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'h0);
        tick();
        in_valid = 1'b0;
        check("bp_overrun",   32'(overrun),   32'h1);
        check("bp_data_held", 32'(data_out),  32'hAA);
        check("bp_valid_held",32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consumed_valid", 32'(out_valid), 32'h0);
        check("bp_overrun_sticky", 32'(overrun),   32'h1);

        // Simultaneous consume and accept
        for (int i = 0; i < 8; i++) push(pat[i], 3'd0);
        check("sim_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        push(1'b1, 3'd0);
        out_ready = 1'b0;
        check("sim_valid", 32'(out_valid), 32'h0);
        check("sim_data",  32'(data_out),  32'hAB);
        check("sim_ptr",   32'(lane_ptr),  32'h1);

        // Explicit mode fill: lanes 7..0 with 8'h5C msb first. The mode change
        // discards the partial auto word (lane 0 already written, ptr=1).
        mode = 1'b1;
        pat  = 8'h5C;
        for (int l = 7; l >= 1; l--) push(pat[l], 3'(l));
        check("expl_valid_before_lane0", 32'(out_valid), 32'h0);
        check("expl_data_partial",       32'(data_out),  32'h5D);
        check("expl_ptr_reset",          32'(lane_ptr),  32'h0);
        push(pat[0], 3'd0);
        check("expl_valid", 32'(out_valid), 32'h1);
        check("expl_data",  32'(data_out),  32'h5C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("expl_consumed", 32'(out_valid), 32'h0);

        // Duplicate explicit lane: lane 3 written 1 then 0, then other lanes 1
        push(1'b1, 3'd3);
        push(1'b0, 3'd3);
        lanes_dup = 8'b1111_0111;
        for (int l = 0; l < 8; l++) begin
            if (lanes_dup[l]) begin
                if (l == 7) check("dup_valid_before_last", 32'(out_valid), 32'h0);
                push(1'b1, 3'(l));
            end
        end
        check("dup_valid", 32'(out_valid), 32'h1);
        check("dup_data",  32'(data_out),  32'hF7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back to auto; reset mid-word after 5 bits
        mode = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) push(1'b1, 3'd0);
        check("mid_ptr", 32'(lane_ptr), 32'h5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_data",    32'(data_out),  32'h00);
        check("mid_rst_ptr",     32'(lane_ptr),  32'h0);
        check("mid_rst_overrun", 32'(overrun),   32'h0);
        check("mid_rst_valid",   32'(out_valid), 32'h0);
        pat = 8'h3C;
        for (int i = 0; i < 7; i++) push(pat[i], 3'd0);
        check("post_rst_valid_before_last", 32'(out_valid), 32'h0);
        push(pat[7], 3'd0);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_data",  32'(data_out),  32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1_8_deser.md
Name: demux_1_8_deser

Overview:
- Sequential 1-to-8 demultiplexer and deserializer. It is the receive-side counterpart of the 8:1 mux: it takes one serial bit per accepted cycle and steers it into a lane of an 8-bit output word.
- Lane selection is either automatic (an internal pointer) or explicit (a `select` input).
- It presents the completed word with a valid/ready handshake. It sits between a serial source and a parallel consumer.

Parameters:
- WIDTH, 8, number of lanes (output word width).
- SEL_W, 3, lane-index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- data_in  input  1  serial data bit.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block accepts data_in this cycle.
- mode  input  1  0 = auto lane pointer, 1 = explicit lane from select.
- select  input  SEL_W  target lane when mode=1; ignored when mode=0.
- data_out  output  WIDTH  assembled word; lane k = bit k.
- out_valid  output  1  data_out holds a complete word.
- out_ready  input  1  consumer takes the word.
- lane_ptr  output  SEL_W  next auto lane.
- overrun  output  1  sticky flag: a bit was offered while in_ready=0.

Behaviour:
- **Reset.** rst_n sampled low at a rising edge gives:
  - data_out=0, out_valid=0, lane_ptr=0, internal written-mask=0, overrun=0, stored mode=0, state=COLLECT.
  - Reset overrides all other activity, including mid-word and HOLD.
- **States:** COLLECT, HOLD.
- **Acceptance.** accept = in_valid & in_ready.
- **in_ready** (combinational):
  - 1 in COLLECT.
  - In HOLD, in_ready = out_ready.
- **COLLECT, on accept:**
  - Lane L = lane_ptr if mode=0, else select.
  - data_out[L] <= data_in; mask[L] <= 1.
  - If mode=0: lane_ptr <= lane_ptr+1, wrapping WIDTH-1 -> 0.
  - In explicit mode, writing an already-written lane overwrites the bit; the mask is unchanged.
- **Completion.** When the accept makes the mask all-ones:
  - Next state HOLD and out_valid <= 1, so out_valid is visible the cycle after the completing edge.
  - mask <= 0; lane_ptr <= 0.
- **HOLD, data frozen.** data_out is stable while out_valid=1 and out_ready=0.
- **HOLD, consume without input.** out_ready=1 and no accept: out_valid <= 0, state <= COLLECT, data_out retained until overwritten lane by lane.
- **HOLD, simultaneous consume and accept.** out_ready=1 and accept in the same cycle:
  - The word is consumed and out_valid <= 0.
  - The incoming bit is written as the first bit of the next word, using the COLLECT rules: lane 0 in auto mode, select in explicit mode.
  - State <= COLLECT.
- **Overrun.** in_valid=1 while in_ready=0: the bit is dropped and overrun <= 1. overrun clears only on reset.
- **Mode change.** mode is registered each cycle. If mode differs from the stored value while in COLLECT:
  - The partial word is discarded: mask <= 0, lane_ptr <= 0; data_out bits are not cleared.
  - A bit accepted in that same cycle is written under the new mode as the first bit of a new word.
  - A mode change in HOLD does not affect the held word.
- **Idle.** No accept means no state change except the mode tracking above.
- **Throughput.** One bit per cycle. A full word takes WIDTH accepts plus one cycle to out_valid.

Test Plan:
- **Auto mode fill.** mode=0, out_ready=0; accept bits 0,1,0,1,0,1,0,1 (lane 0 first) on 8 consecutive cycles -> out_valid=1 one cycle after the 8th edge, data_out=8'b10101010, lane_ptr=0.
- **Explicit mode fill.** mode=1; write lanes 7..0 with the bits of 8'h5C, msb first -> data_out=8'h5C and out_valid=1 only after lane 0 is written.
- **Duplicate explicit lane.** mode=1; select=3 with data 1, then select=3 with data 0, then the other 7 lanes with 1 -> data_out=8'b11110111, out_valid rises only after the 8th distinct lane.
- **Backpressure.** Hold 8'hAA with out_ready=0; drive in_valid=1, data_in=1 -> in_ready=0, overrun=1, data_out stays 8'hAA. Then out_ready=1 for one cycle -> out_valid=0, overrun stays 1.
- **Simultaneous consume and accept.** In HOLD with 8'hAA, mode=0; out_ready=1 and in_valid=1, data_in=1 in the same cycle -> next cycle out_valid=0, data_out[0]=1, lane_ptr=1.
- **Reset mid-word.** Accept 5 bits in auto mode, then rst_n=0 for one edge -> data_out=0, lane_ptr=0, overrun=0. The next 8 accepted bits form a complete word with out_valid=1.
